// File: rtl/ysyx_mem_arbiter.sv
// ysyx_mem_arbiter: shares one memory port between the IFU (read-only) and
// the LSU (load/store). Fixed LSU priority, one transaction in flight, the
// response is routed back to the owning master, and a cycle counter turns a
// silent memory into an error response after TIMEOUT cycles (0 = disabled).
module ysyx_mem_arbiter #(
  parameter int unsigned TIMEOUT = 1000,
  parameter int unsigned CNT_W   = 10
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        ifu_req_valid_i,
  output logic        ifu_req_ready_o,
  input  logic [31:0] ifu_addr_i,
  output logic        ifu_resp_valid_o,
  output logic        ifu_resp_err_o,
  output logic [31:0] ifu_rdata_o,
  input  logic        lsu_req_valid_i,
  output logic        lsu_req_ready_o,
  input  logic [31:0] lsu_addr_i,
  input  logic        lsu_wen_i,
  input  logic [31:0] lsu_wdata_i,
  input  logic [3:0]  lsu_wmask_i,
  output logic        lsu_resp_valid_o,
  output logic        lsu_resp_err_o,
  output logic [31:0] lsu_rdata_o,
  output logic        mem_req_valid_o,
  input  logic        mem_req_ready_i,
  output logic [31:0] mem_addr_o,
  output logic        mem_wen_o,
  output logic [31:0] mem_wdata_o,
  output logic [3:0]  mem_wmask_o,
  input  logic        mem_resp_valid_i,
  input  logic [31:0] mem_rdata_i
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2
  } state_e;

  // Counter value seen during the cycle that is TIMEOUT cycles after acceptance.
  localparam logic             TO_EN   = (TIMEOUT != 0);
  localparam logic [CNT_W-1:0] TO_LAST = (TIMEOUT > 0) ? CNT_W'(TIMEOUT - 1) : '0;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_e            state_q, state_d;
  logic              owner_q, owner_d;   // 0 = IFU, 1 = LSU
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [31:0]       addr_q, addr_d;
  logic              wen_q, wen_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [3:0]        wmask_q, wmask_d;

  logic              timeout_s;
  logic              resp_valid_s;
  logic              resp_err_s;
  logic [31:0]       resp_data_s;

  assign timeout_s = TO_EN && (state_q != ST_IDLE) && (cnt_q >= TO_LAST);

  assign mem_addr_o  = addr_q;
  assign mem_wen_o   = wen_q;
  assign mem_wdata_o = wdata_q;
  assign mem_wmask_o = wmask_q;

  // Next-state, payload capture, handshakes and response generation.
  always_comb begin
    state_d         = state_q;
    owner_d         = owner_q;
    cnt_d           = cnt_q;
    addr_d          = addr_q;
    wen_d           = wen_q;
    wdata_d         = wdata_q;
    wmask_d         = wmask_q;
    ifu_req_ready_o = 1'b0;
    lsu_req_ready_o = 1'b0;
    mem_req_valid_o = 1'b0;
    resp_valid_s    = 1'b0;
    resp_err_s      = 1'b0;
    resp_data_s     = 32'h0000_0000;

    case (state_q)
      ST_IDLE: begin
        lsu_req_ready_o = 1'b1;
        ifu_req_ready_o = ~lsu_req_valid_i;
        if (lsu_req_valid_i) begin
          owner_d = 1'b1;
          addr_d  = lsu_addr_i;
          wen_d   = lsu_wen_i;
          wdata_d = lsu_wdata_i;
          wmask_d = lsu_wmask_i;
          cnt_d   = '0;
          state_d = ST_REQ;
        end else if (ifu_req_valid_i) begin
          owner_d = 1'b0;
          addr_d  = ifu_addr_i;
          wen_d   = 1'b0;
          wdata_d = 32'h0000_0000;
          wmask_d = 4'h0;
          cnt_d   = '0;
          state_d = ST_REQ;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_REQ: begin
        cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1);
        if (timeout_s) begin
          // Withdraw the request and report the error in the same cycle.
          resp_valid_s = 1'b1;
          resp_err_s   = 1'b1;
          state_d      = ST_IDLE;
        end else begin
          mem_req_valid_o = 1'b1;
          if (mem_req_ready_i) begin
            state_d = ST_WAIT;
          end else begin
            state_d = ST_REQ;
          end
        end
      end
      ST_WAIT: begin
        cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1);
        if (mem_resp_valid_i) begin
          // A real response wins over a coincident timeout.
          resp_valid_s = 1'b1;
          resp_data_s  = mem_rdata_i;
          state_d      = ST_IDLE;
        end else if (timeout_s) begin
          resp_valid_s = 1'b1;
          resp_err_s   = 1'b1;
          state_d      = ST_IDLE;
        end else begin
          state_d = ST_WAIT;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Route the single response to its owner; the other master sees zeros.
  always_comb begin
    ifu_resp_valid_o = resp_valid_s & ~owner_q;
    ifu_resp_err_o   = resp_err_s & ~owner_q;
    ifu_rdata_o      = owner_q ? 32'h0000_0000 : resp_data_s;
    lsu_resp_valid_o = resp_valid_s & owner_q;
    lsu_resp_err_o   = resp_err_s & owner_q;
    lsu_rdata_o      = owner_q ? resp_data_s : 32'h0000_0000;
  end

  // State, owner, timeout counter and latched memory payload.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= ST_IDLE;
      owner_q <= 1'b0;
      cnt_q   <= '0;
      addr_q  <= 32'h0000_0000;
      wen_q   <= 1'b0;
      wdata_q <= 32'h0000_0000;
      wmask_q <= 4'h0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      wen_q   <= wen_d;
      wdata_q <= wdata_d;
      wmask_q <= wmask_d;
    end
  end

endmodule
